rf_mp: RTL and testbench
========================

Name: rf_mp

Overview:
Parameterised multi-port register file. It is the next-generation integer register file for the core, built for dual-issue and wider datapaths. It provides N combinational read ports with same-cycle write-to-read bypass and M write ports with fixed priority. A per-register busy scoreboard lets the issue stage reserve a destination and the writeback stage release it. It sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
DATA_WIDTH, 32, width of each register.
NUM_REGISTERS, 32, register count; must be a power of 2 and at least 2.
NUM_READ_PORTS, 2, number of read ports (1..8).
NUM_WRITE_PORTS, 1, number of write ports (1..4).
ZERO_REG, 1, when 1 register 0 is hardwired to zero and can never be busy.
BYPASS, 1, when 1 same-cycle write data is forwarded to matching reads.
ADDR_WIDTH, $clog2(NUM_REGISTERS), localparam.

Ports:
clk  in  1  clock; all state updates on the rising edge.
arst_n  in  1  reset, active-low, synchronous (sampled on the rising edge of clk).
wr_en_in  in  NUM_WRITE_PORTS  per-port write enable.
wr_addr_in  in  NUM_WRITE_PORTS*ADDR_WIDTH  write addresses; port k is in slice k.
wr_data_in  in  NUM_WRITE_PORTS*DATA_WIDTH  write data.
rs_addr_in  in  NUM_READ_PORTS*ADDR_WIDTH  read addresses.
rs_data_out  out  NUM_READ_PORTS*DATA_WIDTH  read data.
rs_busy_out  out  NUM_READ_PORTS  busy bit of each addressed register.
rsv_en_in  in  1  reserve a destination register this cycle.
rsv_addr_in  in  ADDR_WIDTH  register to mark busy.
busy_vec_out  out  NUM_REGISTERS  full scoreboard.

Behaviour:
- Reset: arst_n is sampled low at a rising edge.
  - All registers are set to 0 and all busy bits to 0 at that edge.
  - While arst_n is low, writes and reservations are ignored, bypass is disabled, and rs_data_out and rs_busy_out read 0.
- Write:
  - Takes effect at the rising edge when wr_en_in[k]=1. The new value is visible through the array on the following cycle.
  - With ZERO_REG=1, a write to address 0 is dropped.
- Write collision: when several ports write the same address in one cycle, the highest-index port wins. The other ports' data is discarded silently.
- Read: combinational, zero latency.
  - Read data is 0 when ZERO_REG=1 and the address is 0.
  - Otherwise, with BYPASS=1 and any enabled write port matching the address this cycle, read data is that port's wr_data_in (highest-index match).
  - Otherwise read data is the stored value.
- Scoreboard:
  - rsv_en_in=1 sets busy[rsv_addr_in] at the edge.
  - Any enabled write to address a clears busy[a] at the edge.
  - Reserve and write to the same address in the same cycle leaves busy=1: the reservation belongs to a newer instruction.
  - With ZERO_REG=1, reserving address 0 is ignored.
- rs_busy_out[i]:
  - Equals busy[rs_addr_i], except that with BYPASS=1 it reads 0 when a write to that address is in flight this cycle.
  - Always reads 0 for address 0 when ZERO_REG=1.
- Reserving an already-busy register keeps it busy. This is a legal WAW case; no error is flagged.
- Writing a non-busy register is legal and leaves busy=0.
- A reset asserted mid-operation wins over every same-cycle write and reservation.
- No combinational path exists from outputs back to inputs other than addr/data to read data through bypass.

Test Plan:
- Reset with all registers preloaded to 0xFFFFFFFF, then hold arst_n low for 1 edge → next cycle all reads and busy_vec_out are 0.
- Write 0xDEADBEEF to r5 on port 0 while reading r5 on port 1 in the same cycle → BYPASS=1: rs_data_out=0xDEADBEEF that cycle. BYPASS=0: old value that cycle, 0xDEADBEEF the next cycle.
- Ports 0 and 1 (NUM_WRITE_PORTS=2) write r7 with 0x11 and 0x22 in the same cycle → r7 reads 0x22 afterwards.
- Write 0x1234 to r0 with ZERO_REG=1 → r0 reads 0. Reserve r0 → busy_vec_out[0] stays 0.
- Reserve r3, then write r3 two cycles later → busy[3]=1 for 2 cycles, then 0. Reserve and write r3 in the same cycle → busy[3] stays 1.
- Assert arst_n low in the same cycle as a write of 0xAA to r9 and a reservation of r9 → r9=0 and busy[9]=0 afterwards.

Source files
------------

// File: rtl/rf_mp.sv
// rf_mp -- parameterised multi-port integer register file.
//
// Provides NUM_READ_PORTS combinational read ports, with optional same-cycle
// write-to-read bypass. It also provides NUM_WRITE_PORTS write ports. When
// several ports write one address, the highest-index port wins. A per-register
// busy scoreboard lets issue reserve a destination and writeback release it.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   arst_n         active-low reset, sampled on the rising edge of clk
//   wr_en_in       per-port write enable
//   wr_addr_in     write addresses, port k in slice k
//   wr_data_in     write data, port k in slice k
//   rs_addr_in     read addresses, port i in slice i
//   rs_data_out    read data, port i in slice i
//   rs_busy_out    busy bit of each addressed register
//   rsv_en_in      reserve a destination register this cycle
//   rsv_addr_in    register to mark busy
//   busy_vec_out   full scoreboard
//
// Handshake: none. Writes and reservations are single-cycle strobes with no
// backpressure. Reads are purely combinational and carry no valid/ready.
module rf_mp #(
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_REGISTERS   = 32,
   parameter int NUM_READ_PORTS  = 2,
   parameter int NUM_WRITE_PORTS = 1,
   parameter int ZERO_REG        = 1,
   parameter int BYPASS          = 1,
   localparam int ADDR_WIDTH     = $clog2(NUM_REGISTERS)
) (
   input  logic                                  clk,
   input  logic                                  arst_n,
   input  logic [NUM_WRITE_PORTS-1:0]            wr_en_in,
   input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr_in,
   input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data_in,
   input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  rs_addr_in,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rs_data_out,
   output logic [NUM_READ_PORTS-1:0]             rs_busy_out,
   input  logic                                  rsv_en_in,
   input  logic [ADDR_WIDTH-1:0]                 rsv_addr_in,
   output logic [NUM_REGISTERS-1:0]              busy_vec_out
);

   logic [DATA_WIDTH-1:0]      regs [NUM_REGISTERS];
   logic [NUM_REGISTERS-1:0]   busy;
   logic [NUM_REGISTERS-1:0]   busy_nxt;
   logic [NUM_WRITE_PORTS-1:0] wr_ok;
   logic                       rsv_ok;

   // A write port is effective only if enabled and not aimed at the
   // hardwired zero register. Everything downstream uses this qualified view.
   always_comb begin
      wr_ok = '0;
      for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
         wr_ok[k] = wr_en_in[k] &&
                    !((ZERO_REG != 0) && (wr_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH] == '0));
      end
      rsv_ok = rsv_en_in && !((ZERO_REG != 0) && (rsv_addr_in == '0));
   end

   // Ascending port order means the last assignment, the highest-index port,
   // wins on an address collision.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
            if (wr_ok[k]) begin
               regs[wr_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Writeback releases are applied first and the reservation last. A
   // same-cycle reserve/write pair therefore leaves the register busy, because
   // the reservation belongs to the younger instruction.
   always_comb begin
      busy_nxt = busy;
      for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
         if (wr_ok[k]) begin
            busy_nxt[wr_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
         end
      end
      if (rsv_ok) begin
         busy_nxt[rsv_addr_in] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_nxt[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   assign busy_vec_out = busy;

   // Read ports work as follows:
   //   1. Start from the stored value.
   //   2. Override it with any matching in-flight write, the highest port last.
   //      A register being written this cycle is reported not busy.
   //   3. Force the zero register to zero.
   //   4. Force all read outputs to zero while reset is held low.
   always_comb begin
      rs_data_out = '0;
      rs_busy_out = '0;
      for (int i = 0; i < NUM_READ_PORTS; i++) begin
         logic [ADDR_WIDTH-1:0] ra;
         logic [DATA_WIDTH-1:0] rd;
         logic                  rb;
         ra = rs_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
         rd = regs[ra];
         rb = busy[ra];
         if (BYPASS != 0) begin
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
               if (wr_ok[k] && (wr_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
                  rd = wr_data_in[k*DATA_WIDTH +: DATA_WIDTH];
                  rb = 1'b0;
               end
            end
         end
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rd = '0;
            rb = 1'b0;
         end
         if (!arst_n) begin
            rd = '0;
            rb = 1'b0;
         end
         rs_data_out[i*DATA_WIDTH +: DATA_WIDTH] = rd;
         rs_busy_out[i] = rb;
      end
   end

endmodule

// File: tb/tb_rf_mp.sv
module tb_rf_mp;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          arst_n;
   logic [1:0]    wr_en;
   logic [2*AW-1:0] wr_addr;
   logic [2*DW-1:0] wr_data;
   logic [2*AW-1:0] rs_addr;
   logic          rsv_en;
   logic [AW-1:0] rsv_addr;

   logic [2*DW-1:0] bp_data, nb_data;
   logic [1:0]    bp_busy, nb_busy;
   logic [NR-1:0] bp_vec, nb_vec;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [DW-1:0] m_regs [NR];
   logic [NR-1:0] m_busy;

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run time limit reached (actual running, required finished)");
      $fatal(1);
   end

   rf_mp #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_READ_PORTS(2),
           .NUM_WRITE_PORTS(2), .ZERO_REG(1), .BYPASS(1)) u_bp (
      .clk(clk), .arst_n(arst_n), .wr_en_in(wr_en), .wr_addr_in(wr_addr),
      .wr_data_in(wr_data), .rs_addr_in(rs_addr), .rs_data_out(bp_data),
      .rs_busy_out(bp_busy), .rsv_en_in(rsv_en), .rsv_addr_in(rsv_addr),
      .busy_vec_out(bp_vec));

   rf_mp #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_READ_PORTS(2),
           .NUM_WRITE_PORTS(2), .ZERO_REG(1), .BYPASS(0)) u_nb (
      .clk(clk), .arst_n(arst_n), .wr_en_in(wr_en), .wr_addr_in(wr_addr),
      .wr_data_in(wr_data), .rs_addr_in(rs_addr), .rs_data_out(nb_data),
      .rs_busy_out(nb_busy), .rsv_en_in(rsv_en), .rsv_addr_in(rsv_addr),
      .busy_vec_out(nb_vec));

   // reference model
   function automatic logic [31:0] exp_data(input logic [AW-1:0] a, input bit byp);
      logic [31:0] d;
      d = m_regs[a];
      if (byp) begin
         for (int k = 0; k < 2; k++) begin
            if (wr_en[k] && wr_addr[k*AW +: AW] == a && a != 0) d = wr_data[k*DW +: DW];
         end
      end
      if (a == 0) d = 32'h0;
      if (!arst_n) d = 32'h0;
      return d;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
      logic b;
      b = m_busy[a];
      if (byp) begin
         for (int k = 0; k < 2; k++) begin
            if (wr_en[k] && wr_addr[k*AW +: AW] == a && a != 0) b = 1'b0;
         end
      end
      if (a == 0) b = 1'b0;
      if (!arst_n) b = 1'b0;
      return b;
   endfunction

   // driver tasks
   task automatic idle();
      wr_en  = 2'b00;
      rsv_en = 1'b0;
   endtask

   task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en[k] = 1'b1;
      wr_addr[k*AW +: AW] = a;
      wr_data[k*DW +: DW] = d;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rs_addr = {a1, a0};
   endtask

   // Clock edge: the model commits the inputs seen at the edge, then control
   // returns at the falling edge so the next stimulus can be driven.
   task automatic tick();
      @(posedge clk);
      if (!arst_n) begin
         for (int r = 0; r < NR; r++) m_regs[r] = '0;
         m_busy = '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (wr_en[k] && wr_addr[k*AW +: AW] != 0) begin
               m_regs[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
               m_busy[wr_addr[k*AW +: AW]] = 1'b0;
            end
         end
         if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      end
      @(negedge clk);
   endtask

   // scoreboard: push expectations for both instances, then pop and compare
   task automatic check_outputs(input string name);
      logic [31:0] e;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(exp_data(rs_addr[i*AW +: AW], 1'b1));
         exp_q.push_back({31'b0, exp_busy(rs_addr[i*AW +: AW], 1'b1)});
         exp_q.push_back(exp_data(rs_addr[i*AW +: AW], 1'b0));
         exp_q.push_back({31'b0, exp_busy(rs_addr[i*AW +: AW], 1'b0)});
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (bp_data[i*DW +: DW] !== e) begin
            errors++;
            $display("FAIL %s rd%0d bypass data: got %h expected %h", name, i, bp_data[i*DW +: DW], e);
         end
         e = exp_q.pop_front();
         checks++;
         if ({31'b0, bp_busy[i]} !== e) begin
            errors++;
            $display("FAIL %s rd%0d bypass busy: got %b expected %b", name, i, bp_busy[i], e[0]);
         end
         e = exp_q.pop_front();
         checks++;
         if (nb_data[i*DW +: DW] !== e) begin
            errors++;
            $display("FAIL %s rd%0d nobypass data: got %h expected %h", name, i, nb_data[i*DW +: DW], e);
         end
         e = exp_q.pop_front();
         checks++;
         if ({31'b0, nb_busy[i]} !== e) begin
            errors++;
            $display("FAIL %s rd%0d nobypass busy: got %b expected %b", name, i, nb_busy[i], e[0]);
         end
      end
   endtask

   task automatic check_vec(input string name);
      checks++;
      if (bp_vec !== m_busy) begin
         errors++;
         $display("FAIL %s bypass busy_vec: got %h expected %h", name, bp_vec, m_busy);
      end
      checks++;
      if (nb_vec !== m_busy) begin
         errors++;
         $display("FAIL %s nobypass busy_vec: got %h expected %h", name, nb_vec, m_busy);
      end
   endtask

   // scenarios
   task automatic test_reset();
      for (int r = 1; r < NR; r++) begin
         idle();
         set_wr(0, AW'(r), 32'hFFFF_FFFF);
         rsv_en = 1'b1;
         rsv_addr = AW'(r);
         tick();
      end
      idle();
      set_rd(5'd5, 5'd31);
      check_outputs("preload");
      check_vec("preload");
      arst_n = 1'b0;
      set_wr(1, 5'd9, 32'h0000_0055);
      rsv_en = 1'b1;
      rsv_addr = 5'd9;
      set_rd(5'd9, 5'd5);
      check_outputs("reset_low");
      tick();
      arst_n = 1'b1;
      idle();
      for (int r = 0; r < NR; r += 2) begin
         set_rd(AW'(r), AW'(r + 1));
         check_outputs("after_reset");
      end
      check_vec("after_reset");
   endtask

   task automatic test_bypass();
      idle();
      set_wr(0, 5'd5, 32'hDEAD_BEEF);
      set_rd(5'd4, 5'd5);
      check_outputs("bypass_same_cycle");
      tick();
      idle();
      set_rd(5'd5, 5'd5);
      check_outputs("bypass_next_cycle");
   endtask

   task automatic test_collision();
      idle();
      set_wr(0, 5'd7, 32'h11);
      set_wr(1, 5'd7, 32'h22);
      set_rd(5'd7, 5'd5);
      check_outputs("collision_same_cycle");
      tick();
      idle();
      set_rd(5'd7, 5'd7);
      check_outputs("collision_after");
   endtask

   task automatic test_zero_reg();
      idle();
      set_wr(1, 5'd0, 32'h1234);
      rsv_en = 1'b1;
      rsv_addr = 5'd0;
      set_rd(5'd0, 5'd0);
      check_outputs("zero_write");
      tick();
      idle();
      check_outputs("zero_after");
      check_vec("zero_after");
   endtask

   task automatic test_scoreboard();
      idle();
      rsv_en = 1'b1;
      rsv_addr = 5'd3;
      tick();
      idle();
      set_rd(5'd3, 5'd2);
      check_outputs("rsv_cycle1");
      check_vec("rsv_cycle1");
      tick();
      check_outputs("rsv_cycle2");
      check_vec("rsv_cycle2");
      set_wr(0, 5'd3, 32'h0000_0303);
      check_outputs("rsv_write_inflight");
      tick();
      idle();
      check_outputs("rsv_released");
      check_vec("rsv_released");
      // same-cycle reserve + write on port 1 keeps the register busy
      rsv_en = 1'b1;
      rsv_addr = 5'd3;
      set_wr(1, 5'd3, 32'h0000_0404);
      tick();
      idle();
      check_outputs("rsv_and_write");
      check_vec("rsv_and_write");
      // reserving an already busy register keeps it busy
      rsv_en = 1'b1;
      rsv_addr = 5'd3;
      tick();
      idle();
      check_vec("rsv_waw");
      // release, then write a non-busy register
      set_wr(0, 5'd3, 32'h0000_0505);
      tick();
      set_wr(0, 5'd3, 32'h0000_0606);
      tick();
      idle();
      check_outputs("write_not_busy");
      check_vec("write_not_busy");
   endtask

   task automatic test_reset_collision();
      idle();
      set_wr(0, 5'd9, 32'h0000_0077);
      tick();
      arst_n = 1'b0;
      set_wr(0, 5'd9, 32'h0000_00AA);
      rsv_en = 1'b1;
      rsv_addr = 5'd9;
      tick();
      arst_n = 1'b1;
      idle();
      set_rd(5'd9, 5'd9);
      check_outputs("reset_collision");
      check_vec("reset_collision");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 300; n++) begin
         arst_n = ($urandom_range(0, 49) != 0);
         wr_en = 2'($urandom_range(0, 3));
         wr_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         wr_data = {$urandom, $urandom};
         rsv_en = 1'($urandom_range(0, 1));
         rsv_addr = AW'($urandom_range(0, 7));
         set_rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
         check_outputs("random");
         tick();
         check_vec("random");
      end
      arst_n = 1'b1;
      idle();
   endtask

   initial begin
      arst_n = 1'b0;
      wr_en = '0;
      wr_addr = '0;
      wr_data = '0;
      rs_addr = '0;
      rsv_en = 1'b0;
      rsv_addr = '0;
      for (int r = 0; r < NR; r++) m_regs[r] = '0;
      m_busy = '0;
      @(negedge clk);
      tick();
      tick();
      arst_n = 1'b1;
      test_reset();
      test_bypass();
      test_collision();
      test_zero_reg();
      test_scoreboard();
      test_reset_collision();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
